// File: rtl/master_seq_pkg.sv
// Shared types and helpers for the descriptor-driven bus master: FSM states,
// descriptor bit offsets and a saturating counter increment.
package master_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_REQ,
    S_RELEASE,
    S_DONE
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Descriptor layout, LSB first: addr, data, cmd, chk.
  function automatic int desc_data_lsb(int aw);
    return aw;
  endfunction

  function automatic int desc_cmd_bit(int aw, int dw);
    return aw + dw;
  endfunction

  function automatic int desc_chk_bit(int aw, int dw);
    return aw + dw + 1;
  endfunction

  function automatic int desc_width(int aw, int dw);
    return aw + dw + 2;
  endfunction

  localparam int SAT_W = 32;

  // Increment a w-bit counter (w <= SAT_W) held in the low bits, sticking at all ones.
  function automatic logic [SAT_W-1:0] sat_inc(logic [SAT_W-1:0] v, int w);
    logic [SAT_W:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    return ({1'b0, v} >= max_v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/master_seq_if.sv
// Request/acknowledge bus between the sequencing master and its slave; the master
// holds req until ack, then waits for ack low before the next request.
interface master_seq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  req;
  logic                  cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/master_seq_timeout.sv
// Ack-wait watchdog: loads MAX, counts down while enabled; expired is combinational
// and rises in the MAX-th enabled cycle after load. MAX = 0 never expires.
module master_seq_timeout #(
  parameter int MAX = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(MAX);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (MAX != 0) && en && (cnt_q == CW'(1));

endmodule

// File: rtl/master_seq.sv
// Descriptor-driven bus master: fetches ROM[CMD_START..CMD_STOP] and issues each entry
// as a 4-phase req/ack transfer (ROM_LATENCY+3 cycles minimum); stalls on slave ack.
module master_seq
  import master_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int ROM_AW      = 8,
  parameter int CMD_START   = 0,
  parameter int CMD_STOP    = 1,
  parameter int ROM_LATENCY = 1,
  parameter int AUTO_START  = 1,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic                                          loop_en,
  output logic [ROM_AW-1:0]                             rom_addr,
  input  logic [desc_width(ADDR_WIDTH, DATA_WIDTH)-1:0] rom_data,
  master_seq_if.master                                  bus,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          timeout,
  output logic [CNT_W-1:0]                              txn_cnt,
  output logic [CNT_W-1:0]                              err_cnt,
  output logic [DATA_WIDTH-1:0]                         last_rdata
);

  localparam int DATA_LSB = desc_data_lsb(ADDR_WIDTH);
  localparam int CMD_BIT  = desc_cmd_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int CHK_BIT  = desc_chk_bit(ADDR_WIDTH, DATA_WIDTH);
  localparam int LAT_W    = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY);

  localparam logic [ROM_AW-1:0] START_A = ROM_AW'(CMD_START);
  localparam logic [ROM_AW-1:0] STOP_A  = ROM_AW'(CMD_STOP);
  localparam logic [LAT_W-1:0]  LAT_END = LAT_W'(ROM_LATENCY - 1);

  if (CMD_STOP < CMD_START) begin : g_bad_range
    $error("master_seq: CMD_STOP must be >= CMD_START");
  end
  if (ROM_LATENCY < 1) begin : g_bad_latency
    $error("master_seq: ROM_LATENCY must be >= 1");
  end
  if (CNT_W > SAT_W || CNT_W < 1) begin : g_bad_cnt_w
    $error("master_seq: CNT_W must be in 1..32");
  end

  typedef struct packed {
    logic                  chk;
    logic                  cmd;
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
  } desc_t;

  desc_t desc;

  always_comb begin
    desc.addr = rom_data[ADDR_WIDTH-1:0];
    desc.data = rom_data[DATA_LSB +: DATA_WIDTH];
    desc.cmd  = rom_data[CMD_BIT];
    desc.chk  = rom_data[CHK_BIT];
  end

  state_e                state_q,    state_d;
  logic [LAT_W-1:0]      lat_q,      lat_d;
  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic                  req_q,      req_d;
  logic                  cmd_q,      cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [DATA_WIDTH-1:0] exp_q,      exp_d;
  logic                  chk_q,      chk_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  timeout_q,  timeout_d;
  logic [CNT_W-1:0]      txn_q,      txn_d;
  logic [CNT_W-1:0]      err_q,      err_d;
  logic [DATA_WIDTH-1:0] last_q,     last_d;
  logic                  auto_q,     auto_d;
  logic                  expired;

  master_seq_timeout #(
    .MAX (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == S_LOAD),
    .en      (state_q == S_REQ),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    rom_addr_d = rom_addr_q;
    req_d      = req_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    exp_d      = exp_q;
    chk_d      = chk_q;
    busy_d     = busy_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    txn_d      = txn_q;
    err_d      = err_q;
    last_d     = last_q;
    auto_d     = auto_q;

    unique case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          auto_d     = 1'b0;
          rom_addr_d = START_A;
          lat_d      = '0;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          txn_d      = '0;
          err_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (lat_q == LAT_END) begin
          state_d = S_LOAD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_LOAD: begin
        cmd_d   = desc.cmd;
        addr_d  = desc.addr;
        wdata_d = desc.data;
        exp_d   = desc.data;
        chk_d   = desc.chk;
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        // An ack arriving in the expiry cycle still completes the transfer.
        if (bus.ack) begin
          req_d = 1'b0;
          txn_d = CNT_W'(sat_inc(SAT_W'(txn_q), CNT_W));
          if (cmd_q == CMD_READ) begin
            last_d = bus.rdata;
            if (chk_q && (bus.rdata != exp_q)) begin
              err_d = CNT_W'(sat_inc(SAT_W'(err_q), CNT_W));
            end
          end
          state_d = S_RELEASE;
        end else if (expired) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_RELEASE: begin
        if (!bus.ack) begin
          lat_d = '0;
          if (rom_addr_q != STOP_A) begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = S_FETCH;
          end else if (loop_en) begin
            rom_addr_d = START_A;
            state_d    = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      rom_addr_q <= START_A;
      req_q      <= 1'b0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      exp_q      <= '0;
      chk_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      txn_q      <= '0;
      err_q      <= '0;
      last_q     <= '0;
      auto_q     <= (AUTO_START != 0);
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      rom_addr_q <= rom_addr_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      exp_q      <= exp_d;
      chk_q      <= chk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      txn_q      <= txn_d;
      err_q      <= err_d;
      last_q     <= last_d;
      auto_q     <= auto_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign bus.req    = req_q;
  assign bus.cmd    = cmd_q;
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign txn_cnt    = txn_q;
  assign err_cnt    = err_q;
  assign last_rdata = last_q;

endmodule

// File: tb/tb_master_seq.sv
// Directed bench for master_seq: instance A (indices 0..1, TIMEOUT 8, auto start) runs a
// table of whole-run vectors; instance B (indices 2..4, ROM latency 2) exercises looping.
module tb_master_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [65:0] mk(input logic c, input logic w, input logic [31:0] d,
                                     input logic [31:0] a);
    return {c, w, d, a};
  endfunction

  // ---------------- instance A ----------------
  logic        rst_a, start_a, loop_en_a;
  logic [7:0]  rom_addr_a;
  logic [65:0] rom_data_a;
  logic        busy_a, done_a, timeout_a;
  logic [15:0] txn_a, err_a;
  logic [31:0] last_a;
  logic [65:0] rom_a [0:255];
  logic [31:0] mem_a [0:255];
  logic        no_ack_a = 1'b0;
  logic        bad_a = 1'b0;
  int          hold_a = 0;
  int          hold_cnt_a = 0;

  master_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();

  master_seq #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_AW(8), .CMD_START(0), .CMD_STOP(1),
    .ROM_LATENCY(1), .AUTO_START(1), .TIMEOUT(8), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .loop_en(loop_en_a),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .txn_cnt(txn_a), .err_cnt(err_a), .last_rdata(last_a)
  );

  always @(posedge clk) rom_data_a <= rom_a[rom_addr_a];

  assign bus_a.ack   = !no_ack_a && (bus_a.req || (hold_cnt_a != 0));
  assign bus_a.rdata = bad_a ? 32'hDEADBEEF : mem_a[bus_a.addr[7:0]];

  always @(posedge clk) begin
    if (bus_a.req && bus_a.ack) begin
      hold_cnt_a <= hold_a;
      if (bus_a.cmd) mem_a[bus_a.addr[7:0]] <= bus_a.wdata;
    end else if (hold_cnt_a != 0) begin
      hold_cnt_a <= hold_cnt_a - 1;
    end
  end

  // ---------------- instance B ----------------
  logic        rst_b, start_b, loop_en_b;
  logic [7:0]  rom_addr_b;
  logic [65:0] rom_data_b, rom_pipe_b;
  logic        busy_b, done_b, timeout_b;
  logic [15:0] txn_b, err_b;
  logic [31:0] last_b;
  logic [65:0] rom_b [0:255];
  logic [31:0] mem_b [0:255];

  master_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

  master_seq #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_AW(8), .CMD_START(2), .CMD_STOP(4),
    .ROM_LATENCY(2), .AUTO_START(0), .TIMEOUT(0), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .loop_en(loop_en_b),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .txn_cnt(txn_b), .err_cnt(err_b), .last_rdata(last_b)
  );

  always @(posedge clk) begin
    rom_pipe_b <= rom_b[rom_addr_b];
    rom_data_b <= rom_pipe_b;
  end

  assign bus_b.ack   = bus_b.req;
  assign bus_b.rdata = mem_b[bus_b.addr[7:0]];

  always @(posedge clk) begin
    if (bus_b.req && bus_b.ack && bus_b.cmd) mem_b[bus_b.addr[7:0]] <= bus_b.wdata;
  end

  // ---------------- bus monitors (pre-edge samples) ----------------
  int   cyc = 0;
  int   rises_a = 0, cmpl_a = 0, cur_len_a = 0, last_len_a = 0;
  logic req_prev_a = 1'b0, req_prev_b = 1'b0;
  int   last_rise_b = -1;
  int   q_addr_b[$];
  int   q_gap_b[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus_a.req && bus_a.ack) cmpl_a = cmpl_a + 1;
    if (bus_a.req) begin
      cur_len_a  = req_prev_a ? cur_len_a + 1 : 1;
      if (!req_prev_a) rises_a = rises_a + 1;
      last_len_a = cur_len_a;
    end
    req_prev_a = bus_a.req;
    if (bus_b.req && !req_prev_b) begin
      q_addr_b.push_back(int'(rom_addr_b));
      if (last_rise_b >= 0) q_gap_b.push_back(cyc - last_rise_b);
      last_rise_b = cyc;
    end
    req_prev_b = bus_b.req;
  end

  // ---------------- run vectors for instance A ----------------
  typedef struct {
    string       name;
    logic [65:0] d0;
    logic [65:0] d1;
    logic        bad;
    logic        noack;
    int          hold;
    int          exp_txn;
    int          exp_err;
    logic [31:0] exp_last;
    logic        exp_to;
    int          exp_rises;
    int          exp_len;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic apply_vec(input int i);
    rom_a[0] = vecs[i].d0;
    rom_a[1] = vecs[i].d1;
    bad_a    = vecs[i].bad;
    no_ack_a = vecs[i].noack;
    hold_a   = vecs[i].hold;
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1);
  end

  initial begin
    int rises0, cmpl0;
    int exp_addr_b [6];

    vecs[0] = '{"echo",      mk(0,1,32'h0ABCDEF0,32'h10), mk(1,0,32'h0ABCDEF0,32'h10),
                1'b0, 1'b0, 0, 2, 0, 32'h0ABCDEF0, 1'b0, 2, 1};
    vecs[1] = '{"bad_chk",   mk(0,1,32'h0ABCDEF0,32'h10), mk(1,0,32'h0ABCDEF0,32'h10),
                1'b1, 1'b0, 0, 2, 1, 32'hDEADBEEF, 1'b0, 2, 1};
    vecs[2] = '{"bad_nochk", mk(0,1,32'h0ABCDEF0,32'h10), mk(0,0,32'h0ABCDEF0,32'h10),
                1'b1, 1'b0, 0, 2, 0, 32'hDEADBEEF, 1'b0, 2, 1};
    vecs[3] = '{"ack_hold",  mk(0,1,32'h0ABCDEF0,32'h10), mk(1,0,32'h0ABCDEF0,32'h10),
                1'b0, 1'b0, 4, 2, 0, 32'h0ABCDEF0, 1'b0, 2, 1};
    vecs[4] = '{"cmp_miss",  mk(0,1,32'h12345678,32'h20), mk(1,0,32'h12345679,32'h20),
                1'b0, 1'b0, 0, 2, 1, 32'h12345678, 1'b0, 2, 1};
    vecs[5] = '{"timeout",   mk(0,1,32'h12345678,32'h20), mk(1,0,32'h12345679,32'h20),
                1'b0, 1'b1, 0, 0, 0, 32'h12345678, 1'b1, 1, 8};
    vecs[6] = '{"after_to",  mk(0,1,32'h0ABCDEF0,32'h10), mk(1,0,32'h0ABCDEF0,32'h10),
                1'b0, 1'b0, 0, 2, 0, 32'h0ABCDEF0, 1'b0, 2, 1};
    exp_addr_b = '{2, 3, 4, 2, 3, 4};

    rst_a = 1'b1; start_a = 1'b0; loop_en_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; loop_en_b = 1'b0;
    apply_vec(0);
    repeat (3) @(negedge clk);

    check("rst_req",      64'(bus_a.req),   64'd0);
    check("rst_addr",     64'(bus_a.addr),  64'd0);
    check("rst_wdata",    64'(bus_a.wdata), 64'd0);
    check("rst_busy",     64'(busy_a),      64'd0);
    check("rst_done",     64'(done_a),      64'd0);
    check("rst_timeout",  64'(timeout_a),   64'd0);
    check("rst_txn",      64'(txn_a),       64'd0);
    check("rst_last",     64'(last_a),      64'd0);
    check("rst_rom_a",    64'(rom_addr_a),  64'd0);
    check("rst_rom_b",    64'(rom_addr_b),  64'd2);
    check("rst_busy_b",   64'(busy_b),      64'd0);

    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i > 0) apply_vec(i);
      rises0 = rises_a;
      cmpl0  = cmpl_a;
      if (i > 0) pulse_start_a();
      else @(negedge clk);
      check({vecs[i].name, "_busy_at_start"}, 64'(busy_a),    64'd1);
      check({vecs[i].name, "_done_cleared"},  64'(done_a),    64'd0);
      check({vecs[i].name, "_to_cleared"},    64'(timeout_a), 64'd0);
      for (int t = 0; t < 200 && !done_a; t++) @(negedge clk);
      check({vecs[i].name, "_done"},     64'(done_a),             64'd1);
      check({vecs[i].name, "_busy_end"}, 64'(busy_a),             64'd0);
      check({vecs[i].name, "_timeout"},  64'(timeout_a),          64'(vecs[i].exp_to));
      check({vecs[i].name, "_txn"},      64'(txn_a),              64'(vecs[i].exp_txn));
      check({vecs[i].name, "_err"},      64'(err_a),              64'(vecs[i].exp_err));
      check({vecs[i].name, "_last"},     64'(last_a),             64'(vecs[i].exp_last));
      check({vecs[i].name, "_rises"},    64'(rises_a - rises0),   64'(vecs[i].exp_rises));
      check({vecs[i].name, "_acked"},    64'(cmpl_a - cmpl0),     64'(vecs[i].exp_txn));
      check({vecs[i].name, "_req_len"},  64'(last_len_a),         64'(vecs[i].exp_len));
      check({vecs[i].name, "_req_low"},  64'(bus_a.req),          64'd0);
      repeat (2) @(negedge clk);
    end

    // Reset while a request is outstanding, then auto-restart from the first index.
    no_ack_a = 1'b1;
    pulse_start_a();
    for (int t = 0; t < 20 && !bus_a.req; t++) @(negedge clk);
    check("mid_req_high", 64'(bus_a.req), 64'd1);
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_req",  64'(bus_a.req),  64'd0);
    check("mid_rst_busy", 64'(busy_a),     64'd0);
    check("mid_rst_txn",  64'(txn_a),      64'd0);
    check("mid_rst_last", 64'(last_a),     64'd0);
    check("mid_rst_rom",  64'(rom_addr_a), 64'd0);
    no_ack_a = 1'b0;
    cmpl0    = cmpl_a;
    rst_a    = 1'b0;
    for (int t = 0; t < 20 && !bus_a.req; t++) @(negedge clk);
    check("restart_req",  64'(bus_a.req),  64'd1);
    check("restart_rom",  64'(rom_addr_a), 64'd0);
    for (int t = 0; t < 200 && !done_a; t++) @(negedge clk);
    check("restart_done",  64'(done_a),         64'd1);
    check("restart_txn",   64'(txn_a),          64'd2);
    check("restart_acked", 64'(cmpl_a - cmpl0), 64'd2);

    // Instance B: looping over 2..4 with a 2-cycle ROM, a stray start, then loop exit.
    rom_b[2] = mk(0, 1, 32'hA5A50002, 32'h40);
    rom_b[3] = mk(0, 1, 32'h00000033, 32'h44);
    rom_b[4] = mk(1, 0, 32'hA5A50002, 32'h40);
    loop_en_b = 1'b1;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    check("b_busy_at_start", 64'(busy_b), 64'd1);
    for (int t = 0; t < 200 && txn_b < 16'd2; t++) @(negedge clk);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    for (int t = 0; t < 200 && txn_b != 16'd5; t++) @(negedge clk);
    check("b_txn5", 64'(txn_b), 64'd5);
    loop_en_b = 1'b0;
    for (int t = 0; t < 200 && !done_b; t++) @(negedge clk);
    check("b_done",    64'(done_b),    64'd1);
    check("b_busy",    64'(busy_b),    64'd0);
    check("b_timeout", 64'(timeout_b), 64'd0);
    check("b_txn",     64'(txn_b),     64'd6);
    check("b_err",     64'(err_b),     64'd0);
    check("b_last",    64'(last_b),    64'hA5A50002);
    check("b_n_req",   64'(q_addr_b.size()), 64'd6);
    for (int k = 0; k < 6 && k < q_addr_b.size(); k++)
      check($sformatf("b_rom_seq%0d", k), 64'(q_addr_b[k]), 64'(exp_addr_b[k]));
    for (int k = 0; k < q_gap_b.size(); k++)
      check($sformatf("b_gap%0d", k), 64'(q_gap_b[k]), 64'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
